// File: rtl/debug_frame_bridge.sv
// debug_frame_bridge: host-link request framer (SYNC, CMD, CHK) in front of the debug command
// interface. Issues one command strobe per good frame, captures the response burst and sends
// it back as SYNC_TX, LEN, BODY, CHK on a valid/ready stream.
// Optional build macro DBG_FRAME_RX_TIMEOUT_EN adds an inter-byte RX timeout in GET_CMD/GET_CHK.
module debug_frame_bridge #(
  parameter int unsigned BUF_DEPTH    = 16,
  parameter int unsigned RESP_TIMEOUT = 64,
  parameter int unsigned RX_TIMEOUT   = 1024,
  parameter logic [7:0]  SYNC_RX      = 8'hA5,
  parameter logic [7:0]  SYNC_TX      = 8'h5A
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] i_rx_data,
  input  logic       i_rx_valid,
  output logic       o_rx_ready,
  output logic [7:0] o_tx_data,
  output logic       o_tx_valid,
  input  logic       i_tx_ready,
  output logic [7:0] o_debug_cmd,
  output logic       o_debug_cmd_valid,
  input  logic [7:0] i_debug_resp,
  input  logic       i_debug_resp_valid,
  output logic       o_busy,
  output logic       o_resp_truncated,
  output logic [7:0] o_rx_err_count
);

  localparam int unsigned IW = $clog2(BUF_DEPTH);
  localparam int unsigned CW = IW + 1;
  localparam int unsigned TW = $clog2(RESP_TIMEOUT + 1);
  localparam logic [TW-1:0] RespLast = TW'(RESP_TIMEOUT - 1);

  typedef enum logic [3:0] {
    StIdle,
    StGetCmd,
    StGetChk,
    StIssue,
    StCollect,
    StTxHdr,
    StTxLen,
    StTxBody,
    StTxChk
  } state_e;

  state_e r_state, w_state_next;

  logic [7:0]    r_cmd, w_cmd_next;
  logic [CW-1:0] r_count, w_count_next;
  logic [IW-1:0] r_idx, w_idx_next;
  logic [TW-1:0] r_timer, w_timer_next;
  logic [7:0]    r_sum, w_sum_next;
  logic          r_trunc, w_trunc_next;
  logic [7:0]    r_err, w_err_next;
  logic          w_buf_we;

  logic          r_rx_ready;
  logic          r_busy;
  logic          r_cmd_valid;
  logic          r_tx_valid, w_tx_valid_next;
  logic [7:0]    r_tx_data, w_tx_data_next;

  logic [7:0]    r_buf [BUF_DEPTH];

  logic          w_rx_fire;
  logic          w_tx_fire;
  logic          w_buf_room;
  logic [7:0]    w_len;
  logic [7:0]    w_err_inc;

  assign w_rx_fire  = i_rx_valid & r_rx_ready;
  assign w_tx_fire  = r_tx_valid & i_tx_ready;
  assign w_buf_room = (r_count < CW'(BUF_DEPTH));
  assign w_len      = 8'(r_count);
  assign w_err_inc  = (r_err == 8'hFF) ? r_err : r_err + 8'd1;

`ifdef DBG_FRAME_RX_TIMEOUT_EN
  localparam int unsigned RTW = $clog2(RX_TIMEOUT + 1);
  localparam logic [RTW-1:0] RxLast = RTW'(RX_TIMEOUT - 1);

  logic [RTW-1:0] r_rx_timer;
  logic           w_rx_wait;
  logic           w_rx_timeout;

  assign w_rx_wait    = ((r_state == StGetCmd) || (r_state == StGetChk)) && !w_rx_fire;
  assign w_rx_timeout = w_rx_wait && (r_rx_timer == RxLast);

  // Inter-byte idle counter; restarts on every accepted byte and on leaving the request states.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_timer <= '0;
    end else if (w_rx_wait && !w_rx_timeout) begin
      r_rx_timer <= r_rx_timer + RTW'(1);
    end else begin
      r_rx_timer <= '0;
    end
  end
`endif

  // Next-state and datapath updates for request parsing, response capture and TX sequencing.
  always_comb begin
    w_state_next = r_state;
    w_cmd_next   = r_cmd;
    w_count_next = r_count;
    w_idx_next   = r_idx;
    w_timer_next = r_timer;
    w_sum_next   = r_sum;
    w_trunc_next = r_trunc;
    w_err_next   = r_err;
    w_buf_we     = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (w_rx_fire && (i_rx_data == SYNC_RX)) begin
          w_state_next = StGetCmd;
        end
      end
      StGetCmd: begin
        // A second SYNC_RX here is a legal command byte, not a resync.
        if (w_rx_fire) begin
          w_cmd_next   = i_rx_data;
          w_state_next = StGetChk;
        end
`ifdef DBG_FRAME_RX_TIMEOUT_EN
        else if (w_rx_timeout) begin
          w_err_next   = w_err_inc;
          w_state_next = StIdle;
        end
`endif
      end
      StGetChk: begin
        if (w_rx_fire) begin
          if (i_rx_data == (r_cmd ^ SYNC_RX)) begin
            w_state_next = StIssue;
          end else begin
            w_err_next   = w_err_inc;
            w_state_next = StIdle;
          end
        end
`ifdef DBG_FRAME_RX_TIMEOUT_EN
        else if (w_rx_timeout) begin
          w_err_next   = w_err_inc;
          w_state_next = StIdle;
        end
`endif
      end
      StIssue: begin
        w_count_next = '0;
        w_timer_next = '0;
        w_sum_next   = 8'h00;
        w_trunc_next = 1'b0;
        w_state_next = StCollect;
      end
      StCollect: begin
        if (i_debug_resp_valid) begin
          if (w_buf_room) begin
            w_buf_we     = 1'b1;
            w_count_next = r_count + CW'(1);
            w_sum_next   = r_sum ^ i_debug_resp;
          end else begin
            w_trunc_next = 1'b1;
          end
        end else if (r_count != '0) begin
          // Burst ended; truncation implies count is already nonzero.
          w_idx_next   = '0;
          w_state_next = StTxHdr;
        end else if (r_timer == RespLast) begin
          w_idx_next   = '0;
          w_state_next = StTxHdr;
        end else begin
          w_timer_next = r_timer + TW'(1);
        end
      end
      StTxHdr: begin
        if (w_tx_fire) begin
          w_state_next = StTxLen;
        end
      end
      StTxLen: begin
        if (w_tx_fire) begin
          w_idx_next   = '0;
          w_state_next = (r_count == '0) ? StTxChk : StTxBody;
        end
      end
      StTxBody: begin
        if (w_tx_fire) begin
          if ({1'b0, r_idx} == (r_count - CW'(1))) begin
            w_state_next = StTxChk;
          end else begin
            w_idx_next = r_idx + IW'(1);
          end
        end
      end
      StTxChk: begin
        if (w_tx_fire) begin
          w_state_next = StIdle;
        end
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  // TX byte for the upcoming state; holds automatically while the sink stalls.
  always_comb begin
    w_tx_valid_next = 1'b0;
    w_tx_data_next  = 8'h00;
    case (w_state_next)
      StTxHdr: begin
        w_tx_valid_next = 1'b1;
        w_tx_data_next  = SYNC_TX;
      end
      StTxLen: begin
        w_tx_valid_next = 1'b1;
        w_tx_data_next  = w_len;
      end
      StTxBody: begin
        w_tx_valid_next = 1'b1;
        w_tx_data_next  = r_buf[w_idx_next];
      end
      StTxChk: begin
        w_tx_valid_next = 1'b1;
        w_tx_data_next  = w_len ^ r_sum;
      end
      default: begin
        w_tx_valid_next = 1'b0;
        w_tx_data_next  = 8'h00;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_cmd       <= 8'h00;
      r_count     <= '0;
      r_idx       <= '0;
      r_timer     <= '0;
      r_sum       <= 8'h00;
      r_trunc     <= 1'b0;
      r_err       <= 8'h00;
      r_rx_ready  <= 1'b0;
      r_busy      <= 1'b0;
      r_cmd_valid <= 1'b0;
      r_tx_valid  <= 1'b0;
      r_tx_data   <= 8'h00;
    end else begin
      r_state     <= w_state_next;
      r_cmd       <= w_cmd_next;
      r_count     <= w_count_next;
      r_idx       <= w_idx_next;
      r_timer     <= w_timer_next;
      r_sum       <= w_sum_next;
      r_trunc     <= w_trunc_next;
      r_err       <= w_err_next;
      r_rx_ready  <= (w_state_next == StIdle) || (w_state_next == StGetCmd) ||
                     (w_state_next == StGetChk);
      r_busy      <= (w_state_next != StIdle);
      r_cmd_valid <= (w_state_next == StIssue);
      r_tx_valid  <= w_tx_valid_next;
      r_tx_data   <= w_tx_data_next;
    end
  end

  // Response capture storage; contents are only meaningful below r_count.
  always_ff @(posedge clk) begin
    if (w_buf_we) begin
      r_buf[r_count[IW-1:0]] <= i_debug_resp;
    end
  end

  assign o_rx_ready        = r_rx_ready;
  assign o_tx_data         = r_tx_data;
  assign o_tx_valid        = r_tx_valid;
  assign o_debug_cmd       = r_cmd;
  assign o_debug_cmd_valid = r_cmd_valid;
  assign o_busy            = r_busy;
  assign o_resp_truncated  = r_trunc;
  assign o_rx_err_count    = r_err;

endmodule

// File: tb/tb_debug_frame_bridge.sv
// Directed bench for debug_frame_bridge: good/bad/junk request frames, silent responder,
// over-long response, stalled sink and reset during transmission.
module tb_debug_frame_bridge;

  logic       clk;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] dbg_cmd;
  logic       dbg_cmd_valid;
  logic [7:0] dbg_resp;
  logic       dbg_resp_valid;
  logic       busy;
  logic       resp_truncated;
  logic [7:0] rx_err_count;

  int n_checks;
  int n_errors;
  int n_strobe;
  logic [7:0] exp_q[$];
  logic [7:0] q_tx[$];
  logic [7:0] resp_q[$];
  logic       prev_stall;
  logic [7:0] prev_data;

  debug_frame_bridge u_dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .i_rx_data         (rx_data),
    .i_rx_valid        (rx_valid),
    .o_rx_ready        (rx_ready),
    .o_tx_data         (tx_data),
    .o_tx_valid        (tx_valid),
    .i_tx_ready        (tx_ready),
    .o_debug_cmd       (dbg_cmd),
    .o_debug_cmd_valid (dbg_cmd_valid),
    .i_debug_resp      (dbg_resp),
    .i_debug_resp_valid(dbg_resp_valid),
    .o_busy            (busy),
    .o_resp_truncated  (resp_truncated),
    .o_rx_err_count    (rx_err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // TX capture, stall stability and command strobe counting, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall) begin
        check_eq("tx_hold_valid", 32'(tx_valid), 32'd1);
        check_eq("tx_hold_data", 32'(tx_data), 32'(prev_data));
      end
      if (tx_valid && tx_ready) q_tx.push_back(tx_data);
      if (dbg_cmd_valid) n_strobe <= n_strobe + 1;
      prev_stall <= tx_valid && !tx_ready;
      prev_data  <= tx_data;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    while (!rx_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!rx_ready) check_eq("rx_ready_wait", 32'(rx_ready), 32'd1);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  // Drives resp_q on consecutive cycles starting the cycle after the strobe.
  task automatic drive_resp();
    @(posedge clk);
    #1;
    foreach (resp_q[i]) begin
      dbg_resp       = resp_q[i];
      dbg_resp_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    dbg_resp_valid = 1'b0;
    resp_q.delete();
  endtask

  task automatic wait_idle(input bit toggle);
    int n;
    n = 0;
    while (busy && n < 500) begin
      @(posedge clk);
      #1;
      if (toggle) tx_ready = ~tx_ready;
      n++;
    end
    check_eq("idle_reached", 32'(busy), 32'd0);
    tx_ready = 1'b1;
  endtask

  task automatic check_frame(input string tag);
    check_eq({tag, "_len"}, 32'(q_tx.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      check_eq(tag, (i < q_tx.size()) ? 32'(q_tx[i]) : 32'hDEAD, 32'(exp_q[i]));
    end
    q_tx.delete();
    exp_q.delete();
  endtask

  initial begin
    int s0;
    int n;
    n_checks       = 0;
    n_errors       = 0;
    n_strobe       = 0;
    rst_n          = 1'b0;
    rx_data        = 8'h00;
    rx_valid       = 1'b0;
    tx_ready       = 1'b1;
    dbg_resp       = 8'h00;
    dbg_resp_valid = 1'b0;

    #12;
    check_eq("rst_rx_ready", 32'(rx_ready), 32'd0);
    check_eq("rst_tx_valid", 32'(tx_valid), 32'd0);
    check_eq("rst_tx_data", 32'(tx_data), 32'd0);
    check_eq("rst_cmd", 32'(dbg_cmd), 32'd0);
    check_eq("rst_cmd_valid", 32'(dbg_cmd_valid), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_trunc", 32'(resp_truncated), 32'd0);
    check_eq("rst_err", 32'(rx_err_count), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("idle_rx_ready", 32'(rx_ready), 32'd1);

    // Good frame, four-byte response.
    s0 = n_strobe;
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'hA4);
    check_eq("t1_strobe", 32'(dbg_cmd_valid), 32'd1);
    check_eq("t1_cmd", 32'(dbg_cmd), 32'h01);
    check_eq("t1_busy", 32'(busy), 32'd1);
    resp_q = '{8'h01, 8'h0E, 8'h00, 8'h00};
    drive_resp();
    wait_idle(1'b0);
    exp_q = '{8'h5A, 8'h04, 8'h01, 8'h0E, 8'h00, 8'h00, 8'h0B};
    check_frame("t1_tx");
    check_eq("t1_nstrobe", 32'(n_strobe - s0), 32'd1);
    check_eq("t1_rx_ready", 32'(rx_ready), 32'd1);

    // Bad checksum, then a good frame.
    s0 = n_strobe;
    send_byte(8'hA5);
    send_byte(8'h03);
    send_byte(8'h00);
    check_eq("t2_no_strobe", 32'(dbg_cmd_valid), 32'd0);
    check_eq("t2_err", 32'(rx_err_count), 32'd1);
    check_eq("t2_busy", 32'(busy), 32'd0);
    send_byte(8'hA5);
    send_byte(8'hF0);
    send_byte(8'h55);
    check_eq("t2_strobe", 32'(dbg_cmd_valid), 32'd1);
    check_eq("t2_cmd", 32'(dbg_cmd), 32'hF0);
    resp_q = '{8'h3C};
    drive_resp();
    wait_idle(1'b0);
    exp_q = '{8'h5A, 8'h01, 8'h3C, 8'h3D};
    check_frame("t2_tx");
    check_eq("t2_nstrobe", 32'(n_strobe - s0), 32'd1);

    // Leading junk, then a silent responder.
    s0 = n_strobe;
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'hA5);
    send_byte(8'hF0);
    send_byte(8'h55);
    check_eq("t3_cmd", 32'(dbg_cmd), 32'hF0);
    repeat (64) @(posedge clk);
    #1;
    check_eq("t4_pre_timeout_valid", 32'(tx_valid), 32'd0);
    check_eq("t4_pre_timeout_busy", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    check_eq("t4_timeout_valid", 32'(tx_valid), 32'd1);
    check_eq("t4_timeout_data", 32'(tx_data), 32'h5A);
    wait_idle(1'b0);
    exp_q = '{8'h5A, 8'h00, 8'h00};
    check_frame("t4_tx");
    check_eq("t3_nstrobe", 32'(n_strobe - s0), 32'd1);
    check_eq("t4_trunc", 32'(resp_truncated), 32'd0);
    check_eq("t3_err", 32'(rx_err_count), 32'd1);

    // 20-byte burst into a 16-byte buffer.
    send_byte(8'hA5);
    send_byte(8'h22);
    send_byte(8'h87);
    for (int i = 0; i < 20; i++) resp_q.push_back(8'(8'h10 + i));
    drive_resp();
    wait_idle(1'b0);
    exp_q.push_back(8'h5A);
    exp_q.push_back(8'h10);
    for (int i = 0; i < 16; i++) exp_q.push_back(8'(8'h10 + i));
    exp_q.push_back(8'h10);
    check_frame("t5_tx");
    check_eq("t5_trunc", 32'(resp_truncated), 32'd1);

    // Stalling sink; truncation flag clears on the next command.
    send_byte(8'hA5);
    send_byte(8'h33);
    send_byte(8'h96);
    resp_q = '{8'h11, 8'h22, 8'h33};
    drive_resp();
    check_eq("t6_trunc_cleared", 32'(resp_truncated), 32'd0);
    wait_idle(1'b1);
    exp_q = '{8'h5A, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
    check_frame("t6_tx");

    // Reset in the middle of transmission.
    send_byte(8'hA5);
    send_byte(8'h44);
    send_byte(8'hE1);
    resp_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    drive_resp();
    n = 0;
    while (q_tx.size() < 3 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("t7_mid_tx", 32'(tx_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("t7_rst_tx_valid", 32'(tx_valid), 32'd0);
    check_eq("t7_rst_busy", 32'(busy), 32'd0);
    check_eq("t7_rst_rx_ready", 32'(rx_ready), 32'd0);
    check_eq("t7_rst_err", 32'(rx_err_count), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    q_tx.delete();
    repeat (3) @(posedge clk);
    #1;
    check_eq("t7_no_tx", 32'(q_tx.size()), 32'd0);
    check_eq("t7_idle_busy", 32'(busy), 32'd0);

    s0 = n_strobe;
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'hA4);
    resp_q = '{8'h7E};
    drive_resp();
    wait_idle(1'b0);
    exp_q = '{8'h5A, 8'h01, 8'h7E, 8'h7F};
    check_frame("t7_tx");
    check_eq("t7_nstrobe", 32'(n_strobe - s0), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/debug_frame_bridge.md
Name: debug_frame_bridge

Overview:
- Transport-side framer upstream of the debug command interface.
- Accepts a framed byte stream from the host link, in the form SYNC, CMD, CHK.
- After a checksum pass, issues a single-cycle command strobe to the debug interface.
- Captures the contiguous response byte burst and re-emits it as a framed, checksummed packet on a valid/ready TX stream.
- Handles one command at a time. No command pipelining.

Parameters:
- BUF_DEPTH, 16: response capture buffer depth in bytes. Power of 2, ≥2.
- RESP_TIMEOUT, 64: cycles allowed from the command strobe to the first response byte.
- RX_TIMEOUT, 1024: inter-byte RX timeout in cycles. Used only with the optional feature.
- SYNC_RX, 8'hA5: request frame sync byte.
- SYNC_TX, 8'h5A: response frame sync byte.

Ports:
- clk  in  1  system clock
- rst_n  in  1  async active-low reset
- rx_data  in  8  host request byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  bridge accepts rx_data
- tx_data  out  8  response frame byte
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  sink accepts tx_data
- debug_cmd  out  8  command to debug interface
- debug_cmd_valid  out  1  one-cycle command strobe
- debug_resp  in  8  response byte from debug interface
- debug_resp_valid  in  1  response byte strobe; no backpressure, bytes contiguous
- busy  out  1  high in any state other than IDLE
- resp_truncated  out  1  sticky; set when response exceeded BUF_DEPTH; cleared on next ISSUE
- rx_err_count  out  8  saturating count of dropped request frames (bad CHK or RX timeout)

Behaviour:
- Reset: clk is the clock; rst_n is asynchronous, active-low.
  - All outputs reset to 0: rx_ready, tx_valid, tx_data, debug_cmd, debug_cmd_valid, busy, resp_truncated, rx_err_count.
  - FSM goes to IDLE; buffer count and timers clear.
  - Reset mid-frame discards all state. No partial TX completes.
- rx_ready is registered. It is 1 in IDLE, GET_CMD and GET_CHK, and 0 elsewhere. A byte transfers when rx_valid && rx_ready.
- IDLE: discard bytes ≠ SYNC_RX. On SYNC_RX go to GET_CMD.
- GET_CMD: latch byte into cmd_reg, go to GET_CHK.
- GET_CHK: required CHK = cmd_reg ^ SYNC_RX.
  - Match: go to ISSUE.
  - Mismatch: rx_err_count += 1 (saturates at 8'hFF), go to IDLE.
  - A SYNC_RX byte received in GET_CMD is taken as CMD. No resync.
- ISSUE: exactly one cycle.
  - debug_cmd = cmd_reg, debug_cmd_valid = 1.
  - Clear buffer count, resp timer and resp_truncated.
  - Go to COLLECT.
- COLLECT, each debug_resp_valid:
  - If count < BUF_DEPTH: write byte at buf[count] and increment count.
  - Else: discard the byte and set resp_truncated.
- COLLECT exit conditions:
  - First cycle with debug_resp_valid = 0 after count ≥ 1 (or after truncation): go to TX_HDR.
  - count = 0 and timer reaches RESP_TIMEOUT: go to TX_HDR with length 0 (timeout frame).
  - Timer counts cycles in COLLECT only.
- TX frame format: SYNC_TX, LEN, BODY[0..LEN-1], CHK.
  - LEN = count (8-bit, zero-extended).
  - CHK = LEN XOR all BODY bytes.
  - A timeout frame is 5A 00 00.
- TX states: TX_HDR → TX_LEN → TX_BODY (skipped if LEN = 0) → TX_CHK → IDLE.
  - tx_valid/tx_data are registered.
  - Advance only on tx_valid && tx_ready.
  - While tx_valid && !tx_ready, tx_data and tx_valid hold stable.
  - tx_valid drops the cycle after the CHK byte transfers, unless already in the next frame. Not possible: IDLE precedes.
- Throughput: one TX byte per cycle when tx_ready is held high.
- Latency: the valid CHK byte transfer at cycle T gives debug_cmd_valid at T+1.
- Requests arriving during COLLECT/TX are back-pressured (rx_ready = 0) and never lost.

Optional Feature:
- Macro: DBG_FRAME_RX_TIMEOUT_EN.
- Defined:
  - In GET_CMD/GET_CHK, a counter increments each cycle with no rx transfer and resets on each transfer.
  - On reaching RX_TIMEOUT: go to IDLE and rx_err_count += 1 (saturating).
- Undefined: no counter logic. GET_CMD/GET_CHK wait indefinitely.

Test Plan:
- Good frame A5 01 A4 with a responder returning 01 0E 00 00 on consecutive cycles: one debug_cmd_valid pulse with debug_cmd = 01, then TX 5A 04 01 0E 00 00 CHK = 04^01^0E = 0B, and busy returns to 0.
- Bad CHK A5 03 00: no debug_cmd_valid, rx_err_count 0→1, next good frame A5 F0 55 is processed normally.
- Leading junk 00 FF A5 F0 55: junk discarded, a single command F0 is issued.
- Responder silent: after 64 cycles in COLLECT, TX 5A 00 00 and resp_truncated stays 0.
- 20-byte burst with BUF_DEPTH = 16: LEN = 10h, first 16 bytes emitted, resp_truncated = 1.
- Sink stalls: tx_ready toggling 1010…: every byte is emitted exactly once and in order, with tx_data stable during stalls. Also assert rst_n mid-TX: tx_valid = 0 immediately and the FSM returns to IDLE.
